// File: rtl/xcvr_cmd_sequencer.sv
// CSR front end for the transceiver reconfiguration bridge: issues one level-held
// command at a time, waits for ack, captures read data, times out and drains hung accesses.
module xcvr_cmd_sequencer #(
  parameter int unsigned CMD_W       = 16,
  parameter int unsigned USER_ADDR_W = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                   i_usr_clk,
  input  logic                   i_usr_rst_n,
  input  logic                   i_csr_wr,
  input  logic                   i_csr_rd,
  input  logic [1:0]             i_csr_addr,
  input  logic [DATA_W-1:0]      i_csr_wrdata,
  output logic [DATA_W-1:0]      o_csr_rddata,
  output logic                   o_csr_rdvalid,
  output logic [CMD_W-1:0]       o_usr_cmd,
  output logic [USER_ADDR_W-1:0] o_usr_addr,
  output logic [DATA_W-1:0]      o_usr_writedata,
  input  logic [DATA_W-1:0]      i_usr_readdata,
  input  logic                   i_usr_ack,
  output logic                   o_busy
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYC != 0);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [1:0] CmdNoop  = 2'd0;
  localparam logic [1:0] CmdRead  = 2'd1;
  localparam logic [1:0] CmdWrite = 2'd2;

  typedef enum logic [2:0] {StIdle, StIssue, StRelease, StDrainHi, StDrainLo} state_e;

  // Reset asserts asynchronously but releases two clocks after the pin deasserts.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_usr_clk or negedge i_usr_rst_n) begin
    if (!i_usr_rst_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [USER_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [1:0]             ctrl_cmd_q, ctrl_cmd_d;
  logic [USER_ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [DATA_W-1:0]      wrdata_q, wrdata_d;
  logic [DATA_W-1:0]      rddata_q, rddata_d;
  logic                   done_q, done_d, timeout_q, timeout_d, rejected_q, rejected_d;
  logic [DATA_W-1:0]      csr_rddata_q, csr_rddata_d, rd_mux;
  logic                   csr_rdvalid_q;

  logic       ctrl_wr, wrdata_wr, status_wr, launch, reject, ack_done, expire;
  logic [1:0] new_cmd;

  assign ctrl_wr   = i_csr_wr && (i_csr_addr == 2'd0);
  assign wrdata_wr = i_csr_wr && (i_csr_addr == 2'd1);
  assign status_wr = i_csr_wr && (i_csr_addr == 2'd3);
  assign new_cmd   = i_csr_wrdata[1:0];
  assign launch    = ctrl_wr && (state_q == StIdle) &&
                     ((new_cmd == CmdRead) || (new_cmd == CmdWrite));
  assign reject    = ctrl_wr && !launch;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    ack_done = 1'b0;
    expire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StIssue;
          cmd_d   = new_cmd;
          addr_d  = i_csr_wrdata[USER_ADDR_W+15:16];
          wd_d    = wrdata_q;
          cnt_d   = '0;
        end
      end
      StIssue: begin
        // Ack takes priority over a timeout expiring on the same cycle.
        if (i_usr_ack) begin
          state_d  = StRelease;
          cmd_d    = CmdNoop;
          ack_done = 1'b1;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          state_d = StDrainHi;
          cmd_d   = CmdNoop;
          expire  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: if (!i_usr_ack) state_d = StIdle;
      StDrainHi: if (i_usr_ack)  state_d = StDrainLo;
      StDrainLo: if (!i_usr_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_cmd_d  = ctrl_cmd_q;
    ctrl_addr_d = ctrl_addr_q;
    wrdata_d    = wrdata_q;
    rddata_d    = rddata_q;
    if (ctrl_wr) begin
      ctrl_cmd_d  = new_cmd;
      ctrl_addr_d = i_csr_wrdata[USER_ADDR_W+15:16];
    end
    if (wrdata_wr) wrdata_d = i_csr_wrdata;
    if (ack_done && (cmd_q == CmdRead)) rddata_d = i_usr_readdata;
    // Sticky bits: write-1-to-clear, a hardware set on the same cycle wins.
    done_d     = (done_q     & ~(status_wr & i_csr_wrdata[1])) | ack_done;
    timeout_d  = (timeout_q  & ~(status_wr & i_csr_wrdata[2])) | expire;
    rejected_d = (rejected_q & ~(status_wr & i_csr_wrdata[3])) | reject;
  end

  always_comb begin
    rd_mux = '0;
    unique case (i_csr_addr)
      2'd0: begin
        rd_mux[1:0]               = ctrl_cmd_q;
        rd_mux[USER_ADDR_W+15:16] = ctrl_addr_q;
      end
      2'd1: rd_mux = wrdata_q;
      2'd2: rd_mux = rddata_q;
      2'd3: rd_mux[3:0] = {rejected_q, timeout_q, done_q, o_busy};
    endcase
    csr_rddata_d = i_csr_rd ? rd_mux : csr_rddata_q;
  end

  always_ff @(posedge i_usr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_q         <= CmdNoop;
      addr_q        <= '0;
      wd_q          <= '0;
      ctrl_cmd_q    <= '0;
      ctrl_addr_q   <= '0;
      wrdata_q      <= '0;
      rddata_q      <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      rejected_q    <= 1'b0;
      csr_rddata_q  <= '0;
      csr_rdvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wd_q          <= wd_d;
      ctrl_cmd_q    <= ctrl_cmd_d;
      ctrl_addr_q   <= ctrl_addr_d;
      wrdata_q      <= wrdata_d;
      rddata_q      <= rddata_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      rejected_q    <= rejected_d;
      csr_rddata_q  <= csr_rddata_d;
      csr_rdvalid_q <= i_csr_rd;
    end
  end

  assign o_busy          = (state_q != StIdle);
  assign o_usr_cmd       = CMD_W'(cmd_q);
  assign o_usr_addr      = addr_q;
  assign o_usr_writedata = wd_q;
  assign o_csr_rddata    = csr_rddata_q;
  assign o_csr_rdvalid   = csr_rdvalid_q;

endmodule

// File: tb/tb_xcvr_cmd_sequencer.sv
// Bench for xcvr_cmd_sequencer: scripted bridge acks, transaction-level expectations
// (command length, busy length, sticky status, captured read data) and directed corners.
module tb_xcvr_cmd_sequencer;

  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_wr, csr_rd;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_rdvalid;
  logic [15:0] usr_cmd, usr_addr;
  logic [31:0] usr_wdata, usr_rdata;
  logic        usr_ack, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rd;

  xcvr_cmd_sequencer #(
    .CMD_W       (16),
    .USER_ADDR_W (16),
    .DATA_W      (32),
    .TIMEOUT_CYC (T)
  ) dut (
    .i_usr_clk       (clk),
    .i_usr_rst_n     (rst_n),
    .i_csr_wr        (csr_wr),
    .i_csr_rd        (csr_rd),
    .i_csr_addr      (csr_addr),
    .i_csr_wrdata    (csr_wdata),
    .o_csr_rddata    (csr_rdata),
    .o_csr_rdvalid   (csr_rdvalid),
    .o_usr_cmd       (usr_cmd),
    .o_usr_addr      (usr_addr),
    .o_usr_writedata (usr_wdata),
    .i_usr_readdata  (usr_rdata),
    .i_usr_ack       (usr_ack),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wr    = 1'b1;
    @(negedge clk);
    csr_wr    = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    csr_addr = a;
    csr_rd   = 1'b1;
    @(negedge clk);
    csr_rd   = 1'b0;
    check({tag, "_valid"}, 32'(csr_rdvalid), 32'd1);
    check(tag, csr_rdata, exp);
    @(negedge clk);
    check({tag, "_vlow"}, 32'(csr_rdvalid), 32'd0);
  endtask

  // Bridge acks d cycles after the command appears and holds ack for h cycles.
  // Expected: completion iff d < T; command visible d+1 (or T) cycles; busy d+h+1 cycles.
  task automatic run_txn(input logic [1:0] cmd, input logic [15:0] addr, input logic [31:0] wd,
                         input int d, input int h, input logic [31:0] rdv);
    bit normal;
    int n_cmd, n_busy, n_bad;
    normal = (d <= T - 1);
    do_write(2'd3, 32'hE);
    do_write(2'd1, wd);
    do_write(2'd0, {addr, 14'b0, cmd});
    n_cmd  = 0;
    n_busy = 0;
    n_bad  = 0;
    for (int i = 0; i < d + h + 3; i++) begin
      if (usr_cmd != 16'd0) begin
        n_cmd++;
        if (usr_cmd != 16'(cmd) || usr_addr != addr || usr_wdata != wd) n_bad++;
      end
      if (busy) n_busy++;
      usr_ack   = (i >= d) && (i < d + h);
      usr_rdata = usr_ack ? rdv : $urandom();
      @(negedge clk);
    end
    usr_ack = 1'b0;
    if (normal && cmd == 2'd1) model_rd = rdv;
    check("cmd_cycles", 32'(n_cmd), 32'(normal ? d + 1 : T));
    check("bridge_outs_stable", 32'(n_bad), 32'd0);
    check("busy_cycles", 32'(n_busy), 32'(d + h + 1));
    do_read(2'd3, normal ? 32'h2 : 32'h4, "status");
    do_read(2'd2, model_rd, "rddata");
    do_read(2'd1, wd, "wrdata");
    do_read(2'd0, {addr, 14'b0, cmd}, "ctrl");
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    csr_wr    = 1'b0;
    csr_rd    = 1'b0;
    csr_addr  = 2'd0;
    csr_wdata = 32'd0;
    usr_ack   = 1'b0;
    usr_rdata = 32'd0;
    model_rd  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_cmd", 32'(usr_cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdvalid", 32'(csr_rdvalid), 32'd0);
    check("rst_rddata", csr_rdata, 32'd0);
    check("rst_addr", 32'(usr_addr), 32'd0);
    check("rst_wdata", usr_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(2'd3, 32'h0, "rst_status");
    do_read(2'd2, 32'h0, "rst_rddata_reg");
    do_read(2'd1, 32'h0, "rst_wrdata_reg");
    do_read(2'd0, 32'h0, "rst_ctrl");

    run_txn(2'd2, 16'h0104, 32'hA5A5_0001, 20, 2, 32'h0);
    run_txn(2'd1, 16'h0200, 32'hA5A5_0001, 7, 1, 32'hDEAD_BEEF);

    // Hung read: command drops after T cycles, late ack is drained and discarded.
    do_write(2'd3, 32'hE);
    do_write(2'd0, {16'h0033, 14'b0, 2'd1});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (usr_cmd == 16'd1) n++;
      @(negedge clk);
    end
    check("to_cmd_cycles", 32'(n), 32'(T));
    do_read(2'd3, 32'h5, "to_status_drain");
    usr_rdata = 32'h0BAD_F00D;
    usr_ack   = 1'b1;
    @(negedge clk);
    usr_ack = 1'b0;
    check("drain_lo_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("drain_idle_busy", 32'(busy), 32'd0);
    do_read(2'd2, model_rd, "to_rddata");
    do_read(2'd3, 32'h4, "to_status_end");

    run_txn(2'd1, 16'h0300, 32'h0000_0000, T - 1, 2, 32'h1357_9BDF);
    run_txn(2'd2, 16'h0301, 32'h2468_ACE0, 0, 1, 32'h0);
    run_txn(2'd1, 16'h0400, 32'h0000_0005, 40, 3, 32'hFFFF_0000);

    // CTRL and WRDATA writes while busy.
    do_write(2'd3, 32'hE);
    do_write(2'd1, 32'h1111_2222);
    do_write(2'd0, {16'h0055, 14'b0, 2'd1});
    do_write(2'd0, {16'h0077, 14'b0, 2'd2});
    check("rej_cmd", 32'(usr_cmd), 32'd1);
    check("rej_addr", 32'(usr_addr), 32'h55);
    check("rej_wd", usr_wdata, 32'h1111_2222);
    do_write(2'd1, 32'h3333_4444);
    check("busy_wd", usr_wdata, 32'h1111_2222);
    do_read(2'd1, 32'h3333_4444, "busy_wrdata");
    do_read(2'd3, 32'h9, "rej_status");
    do_write(2'd3, 32'h8);
    do_read(2'd3, 32'h1, "rej_cleared");
    usr_rdata = 32'hCAFE_0001;
    usr_ack   = 1'b1;
    @(negedge clk);
    usr_ack  = 1'b0;
    model_rd = 32'hCAFE_0001;
    n = 0;
    while (busy && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rej_idle", 32'(busy), 32'd0);
    do_read(2'd3, 32'h2, "rej_done");
    do_read(2'd2, model_rd, "rej_rddata");
    do_write(2'd0, 32'h00AB_FFFF);
    do_read(2'd3, 32'hA, "rej_cmd3");
    do_read(2'd0, 32'h00AB_0003, "ctrl_rsvd");

    // Simultaneous read and write of WRDATA returns the old value.
    csr_addr  = 2'd1;
    csr_wdata = 32'h7777_8888;
    csr_wr    = 1'b1;
    csr_rd    = 1'b1;
    @(negedge clk);
    csr_wr = 1'b0;
    csr_rd = 1'b0;
    check("rw_valid", 32'(csr_rdvalid), 32'd1);
    check("rw_old", csr_rdata, 32'h3333_4444);
    @(negedge clk);
    do_read(2'd1, 32'h7777_8888, "rw_new");

    for (int k = 0; k < 12; k++) begin
      run_txn(2'($urandom_range(1, 2)), 16'($urandom()), $urandom(),
              int'($urandom_range(0, T + 8)), int'($urandom_range(1, 4)), $urandom());
    end

    // Asynchronous reset in the middle of an issued command.
    do_write(2'd0, {16'h0099, 14'b0, 2'd1});
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cmd", 32'(usr_cmd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(usr_addr), 32'd0);
    check("arst_wdata", usr_wdata, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_rd = 32'd0;
    repeat (4) @(negedge clk);
    do_read(2'd3, 32'h0, "arst_status");
    do_read(2'd2, 32'h0, "arst_rddata");
    run_txn(2'd2, 16'h0AAA, 32'h0F0F_0F0F, 4, 1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xcvr_cmd_sequencer.md
Name: xcvr_cmd_sequencer

Overview:
- CSR-facing front end that turns software register accesses into the level-held command/ack handshake consumed by the transceiver reconfiguration AVMM bridge (usr_cmd/usr_addr/usr_writedata in, usr_readdata/usr_ack out).
- Sits in the user clock domain, directly upstream of the bridge.
- Issues one transaction at a time, holds the command until ack, then returns it to NOOP.
- Captures read data, times out hung transactions and drains the bridge afterwards.

Parameters:
- CMD_W, 16, command width; only bits [1:0] are meaningful (0 NOOP, 1 READ, 2 WRITE, 3 reserved).
- USER_ADDR_W, 16, transceiver register address width.
- DATA_W, 32, data width; CSR data width equals DATA_W.
- TIMEOUT_CYC, 4096, user clocks allowed from issue to ack; 0 disables the timeout.

Ports:
- i_usr_clk  in  1  user clock (250 MHz).
- i_usr_rst_n  in  1  reset, asynchronous assert, active-low.
- i_csr_wr  in  1  CSR write strobe, single cycle.
- i_csr_rd  in  1  CSR read strobe, single cycle.
- i_csr_addr  in  2  register select: 0 CTRL, 1 WRDATA, 2 RDDATA, 3 STATUS.
- i_csr_wrdata  in  DATA_W  CSR write data.
- o_csr_rddata  out  DATA_W  CSR read data.
- o_csr_rdvalid  out  1  read data valid.
- o_usr_cmd  out  CMD_W  command to bridge.
- o_usr_addr  out  USER_ADDR_W  address to bridge.
- o_usr_writedata  out  DATA_W  write data to bridge.
- i_usr_readdata  in  DATA_W  read data from bridge.
- i_usr_ack  in  1  ack from bridge (level).
- o_busy  out  1  transaction or drain in progress.

Behaviour:
- Reset (async, active-low) values:
  - All outputs 0; o_usr_cmd = NOOP.
  - RDDATA, WRDATA and STATUS bits 0; FSM = IDLE.
- Reset deassertion is synchronised internally, two flops.
- Registers:
  - CTRL (write): [1:0] cmd, [USER_ADDR_W+15:16] addr.
  - WRDATA: RW.
  - RDDATA: RO, last captured read data.
  - STATUS: [0] busy, [1] done (sticky), [2] timeout (sticky), [3] rejected (sticky). Bits [3:1] are write-1-to-clear.
- CSR reads: o_csr_rddata registered, o_csr_rdvalid pulses exactly 1 cycle after i_csr_rd. Writes take effect the next cycle.
- Reads of CTRL return the last written value. Reads of reserved bits return 0.
- A CTRL write in IDLE with cmd = READ or WRITE launches a transaction:
  - addr and WRDATA are latched into o_usr_addr/o_usr_writedata.
  - o_usr_cmd is driven on the next cycle.
- A CTRL write with cmd = NOOP or 3, or any CTRL write while busy, is ignored and sets STATUS.rejected.
- WRDATA writes while busy update the register only, never the bridge outputs.
- FSM states:
  - IDLE: o_usr_cmd = NOOP, o_busy = 0. Valid CTRL write -> ISSUE.
  - ISSUE: cmd/addr/data held stable, timeout counter counts up from 0.
    - i_usr_ack = 1 -> RELEASE. Capture i_usr_readdata into RDDATA on READ only; set done; o_usr_cmd = NOOP the next cycle.
    - Counter reaches TIMEOUT_CYC-1 without ack -> DRAIN_HI. Set timeout; o_usr_cmd = NOOP.
  - RELEASE: wait for i_usr_ack = 0 -> IDLE.
  - DRAIN_HI: wait for i_usr_ack = 1 (the abandoned transaction completes) -> DRAIN_LO. Read data is discarded and done is not set.
  - DRAIN_LO: wait for i_usr_ack = 0 -> IDLE.
- o_busy = 1 in ISSUE, RELEASE, DRAIN_HI and DRAIN_LO.
- Ack arriving on the same cycle as the timeout expiry: ack wins and the transaction completes normally.
- A CSR write to STATUS on the same cycle as a hardware set: the set wins.
- Simultaneous i_csr_rd and i_csr_wr: both are serviced; the read returns the pre-write value.
- Reset mid-transaction forces IDLE and NOOP. The downstream bridge resets from the same source.
- Counter width is $clog2(TIMEOUT_CYC+1). It saturates and never wraps.

Test Plan:
- Write WRDATA=0xA5A5_0001, then CTRL={addr 0x0104, cmd 2}; bridge model acks after 20 cycles -> o_usr_cmd=2 for exactly 21 cycles, o_usr_addr=0x0104, o_usr_writedata=0xA5A5_0001, then NOOP. STATUS reads 0x2 after ack drops.
- CTRL={addr 0x0200, cmd 1}; model returns 0xDEAD_BEEF with ack -> RDDATA read gives 0xDEADBEEF with rdvalid exactly 1 cycle after rd; WRDATA unchanged.
- TIMEOUT_CYC=16, model never acks for 40 cycles, then acks once -> cmd drops to NOOP at cycle 16, STATUS=0x5 while draining, busy clears 1 cycle after ack falls, RDDATA unchanged.
- Second CTRL write while busy -> ignored, STATUS.rejected=1, bridge outputs unchanged. Writing STATUS=0x8 -> rejected clears.
- Assert i_usr_rst_n=0 mid-ISSUE -> o_usr_cmd=0, o_busy=0, STATUS=0 immediately (async), without waiting for a clock edge.
- Ack on the exact timeout cycle -> done=1, timeout=0, and the next command is accepted normally.
